sram_like_axi_bridge: RTL and testbench

//  Sits directly below mycpu_top_sram_like. Converts its inst and data sram-like ports into one AXI3 master.

---
 rtl/sram_like_axi_bridge_pkg.sv | 35 +++
 rtl/sram_like_axi_bridge_axi_wr_chan.sv | 107 ++++++++++
 rtl/sram_like_axi_bridge.sv | 176 +++++++++++++++++
 tb/tb_sram_like_axi_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_axi_bridge_pkg.sv
// rtl/sram_like_axi_bridge_pkg.sv - shared encodings and constants for the sram-like to AXI3 bridge
// Purpose: read/write FSM state encodings, default AXI IDs, constant AXI field values
//          and the sram-like size to AXI size mapping.
// Ports:   none (package).
package sram_like_axi_bridge_pkg;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;

    localparam logic [2:0] W_IDLE = 3'd0;
    localparam logic [2:0] W_AWW  = 3'd1;
    localparam logic [2:0] W_AW   = 3'd2;
    localparam logic [2:0] W_W    = 3'd3;
    localparam logic [2:0] W_B    = 3'd4;

    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } rd_src_e;

    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_like_axi_bridge_axi_wr_chan.sv
// rtl/sram_like_axi_bridge_axi_wr_chan.sv - write side of the bridge: write FSM plus AW/W/B channels
// Purpose: accepts one data-port write at a time, issues AW and W (in either order or together),
//          waits for B and pulses done.
// Ports:   clk/reset; req/rd_data_busy/req_{size,addr,wstrb,wdata} request side;
//          accept (addr_ok for the write), done (data_ok for the write), wr_busy to the read arbiter;
//          aw*/w*/b* AXI3 write channels.
module axi_wr_chan
    import sram_like_axi_bridge_pkg::*;
#(
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rd_data_busy,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        accept,
    output logic        done,
    output logic        wr_busy,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    logic [2:0]  w_state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    // A write must not overtake a data read already in flight.
    assign accept  = (w_state == W_IDLE) && req && !rd_data_busy;
    assign done    = (w_state == W_B) && bvalid;
    assign wr_busy = (w_state != W_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (accept) begin
                        w_state <= W_AWW;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        wstrb_q <= req_wstrb;
                        wdata_q <= req_wdata;
                    end
                end
                W_AWW: begin
                    if (awready && wready) begin
                        w_state <= W_B;
                    end else if (awready) begin
                        w_state <= W_W;
                    end else if (wready) begin
                        w_state <= W_AW;
                    end
                end
                W_AW: if (awready) w_state <= W_B;
                W_W:  if (wready)  w_state <= W_B;
                W_B:  if (bvalid)  w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN;
    assign awsize  = axi_size(size_q);
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign awvalid = (w_state == W_AWW) || (w_state == W_AW);

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (w_state == W_AWW) || (w_state == W_W);

    assign bready  = (w_state == W_B);

endmodule

// File: rtl/sram_like_axi_bridge.sv
// rtl/sram_like_axi_bridge.sv - inst/data sram-like ports to a single AXI3 master
// Purpose: one outstanding read (data over inst priority) and one outstanding write (data port only).
//          Data reads wait while a write is pending so read-after-write order holds.
// Ports:   clk, reset (async, active-high);
//          inst_sram_* / data_sram_* sram-like request/response ports;
//          ar*/r* AXI3 read channels; aw*/w*/b* AXI3 write channels.
module sram_like_axi_bridge
    import sram_like_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    logic [1:0]  r_state;
    rd_src_e     r_src;
    logic [31:0] ar_addr_q;
    logic [1:0]  ar_size_q;

    logic        wr_busy;
    logic        wr_accept;
    logic        wr_done;
    logic        rd_data_acc;
    logic        rd_inst_acc;
    logic        rd_done;
    logic        rd_data_busy;

    // One outstanding transaction per channel, so IDs/responses carry no information here.
    logic        unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast, bid, bresp};

    assign rd_data_acc  = (r_state == R_IDLE) && data_sram_req && !data_sram_wr && !wr_busy;
    assign rd_inst_acc  = (r_state == R_IDLE) && !rd_data_acc && inst_sram_req;
    assign rd_done      = (r_state == R_R) && rvalid;
    // r_src is stale in R_IDLE, so only trust it while the read FSM is busy.
    assign rd_data_busy = (r_state != R_IDLE) && (r_src == SRC_DATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_src     <= SRC_INST;
            ar_addr_q <= 32'd0;
            ar_size_q <= 2'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_data_acc) begin
                        r_state   <= R_AR;
                        r_src     <= SRC_DATA;
                        ar_addr_q <= data_sram_addr;
                        ar_size_q <= data_sram_size;
                    end else if (rd_inst_acc) begin
                        r_state   <= R_AR;
                        r_src     <= SRC_INST;
                        ar_addr_q <= inst_sram_addr;
                        ar_size_q <= inst_sram_size;
                    end
                end
                R_AR:    if (arready) r_state <= R_R;
                R_R:     if (rvalid)  r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign arid    = (r_src == SRC_DATA) ? DATA_ID : INST_ID;
    assign araddr  = ar_addr_q;
    assign arlen   = AXI_LEN;
    assign arsize  = axi_size(ar_size_q);
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_R);

    axi_wr_chan #(
        .DATA_ID (DATA_ID)
    ) u_wr_chan (
        .clk          (clk),
        .reset        (reset),
        .req          (data_sram_req && data_sram_wr),
        .rd_data_busy (rd_data_busy),
        .req_size     (data_sram_size),
        .req_addr     (data_sram_addr),
        .req_wstrb    (data_sram_wstrb),
        .req_wdata    (data_sram_wdata),
        .accept       (wr_accept),
        .done         (wr_done),
        .wr_busy      (wr_busy),
        .awid         (awid),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awlock       (awlock),
        .awcache      (awcache),
        .awprot       (awprot),
        .awvalid      (awvalid),
        .awready      (awready),
        .wid          (wid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    // Read and write completions for the data port never coincide: a data read and a
    // data write are never outstanding together.
    assign inst_sram_addr_ok = rd_inst_acc;
    assign inst_sram_data_ok = rd_done && (r_src == SRC_INST);
    assign inst_sram_rdata   = rdata;
    assign data_sram_addr_ok = rd_data_acc || wr_accept;
    assign data_sram_data_ok = (rd_done && (r_src == SRC_DATA)) || wr_done;
    assign data_sram_rdata   = rdata;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// tb/tb_sram_like_axi_bridge.sv - self-checking bench for sram_like_axi_bridge
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_aok, inst_dok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_aok, data_dok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_like_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_req), .inst_sram_wr(inst_wr), .inst_sram_size(inst_size),
        .inst_sram_addr(inst_addr), .inst_sram_wstrb(inst_wstrb), .inst_sram_wdata(inst_wdata),
        .inst_sram_addr_ok(inst_aok), .inst_sram_data_ok(inst_dok), .inst_sram_rdata(inst_rdata),
        .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
        .data_sram_wstrb(data_wstrb), .data_sram_addr(data_addr), .data_sram_wdata(data_wdata),
        .data_sram_addr_ok(data_aok), .data_sram_data_ok(data_dok), .data_sram_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // in:  {inst_req, data_req, data_wr, arready, rvalid, awready, wready, bvalid}
    // exp: {inst_aok, inst_dok, data_aok, data_dok, arvalid, arid[0], rready, awvalid, wvalid, bready}
    typedef struct {
        logic [7:0]  in;
        logic [31:0] addr;
        logic [9:0]  exp;
        logic [31:0] araddr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] IADDR = 32'hBFC0_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] in, input logic [31:0] addr, input logic [9:0] exp,
                       input logic [31:0] ara);
        vec_t v;
        v.in = in; v.addr = addr; v.exp = exp; v.araddr = ara;
        vecs.push_back(v);
    endtask

    function automatic logic [9:0] ctl();
        return {inst_aok, inst_dok, data_aok, data_dok, arvalid, arvalid & arid[0],
                rready, awvalid, wvalid, bready};
    endfunction

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = IADDR;
        inst_wstrb = 4'hF; inst_wdata = 32'd0;
        data_req = 0; data_wr = 0; data_size = 2'b10; data_wstrb = 4'b0011;
        data_addr = 32'd0; data_wdata = 32'h1234_5678;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 1; bid = 0; bresp = 0;

        // 1: inst read, slave ready at once
        add(8'b100_11_000, 32'h0,          10'b1000_000_000, 32'h0);
        add(8'b000_11_000, 32'h0,          10'b0000_100_000, IADDR);
        add(8'b000_11_000, 32'h0,          10'b0100_001_000, 32'h0);
        add(8'b000_00_000, 32'h0,          10'b0000_000_000, 32'h0);
        // 2: data read wins over inst read in the same cycle
        add(8'b110_11_000, 32'h8000_1000,  10'b0010_000_000, 32'h0);
        add(8'b100_11_000, 32'h8000_1000,  10'b0000_110_000, 32'h8000_1000);
        add(8'b100_11_000, 32'h8000_1000,  10'b0001_001_000, 32'h0);
        add(8'b100_11_000, 32'h8000_1000,  10'b1000_000_000, 32'h0);
        add(8'b000_11_000, 32'h8000_1000,  10'b0000_100_000, IADDR);
        add(8'b000_11_000, 32'h8000_1000,  10'b0100_001_000, 32'h0);
        add(8'b000_00_000, 32'h0,          10'b0000_000_000, 32'h0);
        // 3: write, awready late by 3 cycles, wready immediate
        add(8'b011_00_010, 32'h8000_2000,  10'b0010_000_000, 32'h0);
        add(8'b000_00_010, 32'h8000_2000,  10'b0000_000_110, 32'h0);
        add(8'b000_00_010, 32'h8000_2000,  10'b0000_000_100, 32'h0);
        add(8'b000_00_010, 32'h8000_2000,  10'b0000_000_100, 32'h0);
        add(8'b000_00_110, 32'h8000_2000,  10'b0000_000_100, 32'h0);
        add(8'b000_00_000, 32'h8000_2000,  10'b0000_000_001, 32'h0);
        add(8'b000_00_001, 32'h8000_2000,  10'b0001_000_001, 32'h0);
        add(8'b000_00_000, 32'h0,          10'b0000_000_000, 32'h0);
        // 4: data read to the written address waits for B; inst read goes meanwhile
        add(8'b011_00_110, 32'h8000_2000,  10'b0010_000_000, 32'h0);
        add(8'b110_10_110, 32'h8000_2000,  10'b1000_000_110, 32'h0);
        add(8'b010_10_000, 32'h8000_2000,  10'b0000_100_001, IADDR);
        add(8'b010_01_000, 32'h8000_2000,  10'b0100_001_001, 32'h0);
        add(8'b010_00_000, 32'h8000_2000,  10'b0000_000_001, 32'h0);
        add(8'b010_00_001, 32'h8000_2000,  10'b0001_000_001, 32'h0);
        add(8'b010_10_000, 32'h8000_2000,  10'b0010_000_000, 32'h0);
        add(8'b000_10_000, 32'h8000_2000,  10'b0000_110_000, 32'h8000_2000);
        add(8'b000_01_000, 32'h8000_2000,  10'b0001_001_000, 32'h0);
        add(8'b000_00_000, 32'h0,          10'b0000_000_000, 32'h0);
        // 5: arready stalled 5 cycles with requests pending on both ports
        add(8'b100_00_000, 32'h8000_4000,  10'b1000_000_000, 32'h0);
        for (int k = 0; k < 5; k++)
            add(8'b110_00_000, 32'h8000_4000, 10'b0000_100_000, IADDR);
        add(8'b110_10_000, 32'h8000_4000,  10'b0000_100_000, IADDR);
        add(8'b110_01_000, 32'h8000_4000,  10'b0100_001_000, 32'h0);
        add(8'b000_00_000, 32'h0,          10'b0000_000_000, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset ctl", {22'd0, ctl()}, 32'd0);
        chk("reset araddr", araddr, 32'd0);
        chk("reset awaddr", awaddr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            {inst_req, data_req, data_wr, arready, rvalid, awready, wready, bvalid} = vecs[i].in;
            data_addr = vecs[i].addr;
            rdata = 32'hC0DE_0000 | i;
            #1;
            chk($sformatf("vec%0d ctl", i), {22'd0, ctl()}, {22'd0, vecs[i].exp});
            if (vecs[i].exp[5])
                chk($sformatf("vec%0d araddr", i), araddr, vecs[i].araddr);
            if (vecs[i].exp[8])
                chk($sformatf("vec%0d inst_rdata", i), inst_rdata, 32'hC0DE_0000 | i);
            if (vecs[i].exp[6] && vecs[i].exp[3])
                chk($sformatf("vec%0d data_rdata", i), data_rdata, 32'hC0DE_0000 | i);
            if (vecs[i].exp[2])
                chk($sformatf("vec%0d awaddr", i), awaddr, vecs[i].addr);
            if (vecs[i].exp[1]) begin
                chk($sformatf("vec%0d wdata", i), wdata, 32'h1234_5678);
                chk($sformatf("vec%0d wstrb", i), {28'd0, wstrb}, 32'h3);
            end
            @(posedge clk); #1;
        end

        // 6: inst read and data write accepted together, reset in R_R/W_B, then a fresh read
        inst_req = 1; data_req = 1; data_wr = 1; data_addr = 32'h8000_3000;
        data_wdata = 32'hA5A5_0F0F; data_wstrb = 4'b1100;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #1;
        chk("dual accept", {30'd0, inst_aok, data_aok}, 32'h3);
        @(posedge clk); #1;
        inst_req = 0; data_req = 0; data_wr = 0; data_addr = 32'd0;
        data_wdata = 32'd0; data_wstrb = 4'd0;
        arready = 1; awready = 1; wready = 1;
        #1;
        chk("dual ar", {31'd0, arvalid}, 32'h1);
        chk("dual araddr", araddr, IADDR);
        chk("dual arsize", {29'd0, arsize}, 32'h2);
        chk("dual aw/w valid", {30'd0, awvalid, wvalid}, 32'h3);
        chk("dual awaddr", awaddr, 32'h8000_3000);
        chk("dual wdata held", wdata, 32'hA5A5_0F0F);
        chk("dual wstrb held", {28'd0, wstrb}, 32'hC);
        chk("aw consts", {awlen, 6'd0, awburst, 6'd0, awsize, 8'd0, wlast}, {8'd0, 6'd0, 2'b01, 6'd0, 3'b010, 8'd0, 1'b1});
        @(posedge clk); #1;
        arready = 0; awready = 0; wready = 0;
        #1;
        chk("in R_R and W_B", {30'd0, rready, bready}, 32'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset ctl", {22'd0, ctl()}, 32'd0);
        chk("async reset aw/ar", {30'd0, awvalid | wvalid, arvalid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post reset ctl", {22'd0, ctl()}, 32'd0);
        inst_req = 1; arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("fresh inst aok", {31'd0, inst_aok}, 32'h1);
        @(posedge clk); #1;
        inst_req = 0;
        #1;
        chk("fresh arvalid", {22'd0, ctl()}, {22'd0, 10'b0000_100_000});
        chk("fresh araddr", araddr, IADDR);
        @(posedge clk); #1;
        chk("fresh inst dok", {22'd0, ctl()}, {22'd0, 10'b0100_001_000});
        chk("fresh rdata", inst_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        arready = 0; rvalid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
